// File: rtl/nexi_uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the UART TX scheduler.
// master = scheduler, slave = producers plus transmitter.
interface nexi_uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              err_timeout;
  logic              uart_send;
  logic [7:0]        uart_data;
  logic              uart_done;

  modport master (
    input  req, req_data, uart_done,
    output req_ack, grant, busy, err_timeout, uart_send, uart_data
  );

  modport slave (
    output req, req_data, uart_done,
    input  req_ack, grant, busy, err_timeout, uart_send, uart_data
  );
endinterface

// File: rtl/nexi_uart_tx_sched.sv
// Round-robin scheduler sharing one nexi_uart_tx between NREQ byte producers,
// with bounded per-grant bursts and an acknowledge timeout.
module nexi_uart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                        clk_1x_bps,
  input  logic                        rst,
  nexi_uart_tx_sched_if.master        bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [7:0]      burst_q, burst_d;
  logic [7:0]      to_q, to_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            send_q, send_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [7:0]      data_q, data_d;

  logic            arb_hit;
  logic [PW-1:0]   arb_idx;
  int              cand;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] w);
    return (int'(w) == NREQ - 1) ? '0 : PW'(int'(w) + 1);
  endfunction

  // Scan downward so the lowest offset from ptr_q wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    burst_d = burst_q;
    to_d    = to_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = 1'b0;
    send_d  = send_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.uart_done && arb_hit) begin
          win_d          = arb_idx;
          grant_d        = '0;
          grant_d[arb_idx] = 1'b1;
          data_d         = bus.req_data[8*int'(arb_idx) +: 8];
          send_d         = 1'b1;
          burst_d        = '0;
          to_d           = '0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (!bus.uart_done) begin
          send_d  = 1'b0;
          ack_d   = grant_q;
          state_d = DRAIN;
        end else if (to_q == TO_LAST) begin
          send_d  = 1'b0;
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = wrap_inc(win_q);
          state_d = IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      DRAIN: begin
        // Transmitter back to idle: either stream the next byte or hand over.
        if (bus.uart_done) begin
          if (bus.req[win_q] && (int'(burst_q) < MAX_BURST - 1)) begin
            burst_d = burst_q + 8'd1;
            data_d  = bus.req_data[8*int'(win_q) +: 8];
            send_d  = 1'b1;
            to_d    = '0;
            state_d = SEND;
          end else begin
            grant_d = '0;
            ptr_d   = wrap_inc(win_q);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_1x_bps or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      burst_q <= '0;
      to_q    <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      burst_q <= burst_d;
      to_q    <= to_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req_ack     = ack_q;
  assign bus.uart_send   = send_q;
  assign bus.uart_data   = data_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_nexi_uart_tx_sched.sv
// Bench for nexi_uart_tx_sched: behavioural transmitter, per-requester byte
// queues and a transaction-level round-robin/burst model.
module tb_nexi_uart_tx_sched;
  localparam int N    = 4;
  localparam int MAXB = 3;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nexi_uart_tx_sched_if #(.NREQ(N)) bus();

  nexi_uart_tx_sched #(.NREQ(N), .MAX_BURST(MAXB), .ACK_TIMEOUT(TO)) dut (
    .clk_1x_bps(clk),
    .rst       (rst),
    .bus       (bus)
  );

  // Transmitter: 2-flop sync + register, then 11 cycles busy (done low).
  logic tx_done = 1'b1, s1 = 1'b0, s2 = 1'b0, stub = 1'b0, hold_low = 1'b0;
  int   fcnt = 0;
  assign bus.uart_done = tx_done & ~hold_low;
  always @(posedge clk) begin
    s1 <= bus.uart_send;
    s2 <= s1;
    if (stub) tx_done <= 1'b1;
    else if (tx_done && s2) begin
      tx_done <= 1'b0;
      fcnt    <= 11;
    end else if (!tx_done) begin
      if (fcnt <= 1) tx_done <= 1'b1;
      else fcnt <= fcnt - 1;
    end
  end

  int   nchk = 0, nerr = 0, nsend = 0;
  logic prev_send = 1'b0;

  logic [7:0] q [N][$];
  int m_ptr = 0, m_owner = -1, m_burst = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.uart_send && !prev_send) nsend++;
    prev_send = bus.uart_send;
  endtask

  // sel: 0 grant nonzero, 1 req_ack nonzero, 2 err_timeout
  task automatic wait_sig(input int sel, input int lim, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      tick();
      case (sel)
        0:       hit = |bus.grant;
        1:       hit = |bus.req_ack;
        default: hit = bus.err_timeout;
      endcase
    end
    chk({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.req_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0; m_owner = -1; m_burst = 0;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (q[i].size() != 0);
      bus.req_data[8*i +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  // Every ack must come from the requester the rotation/burst rules predict.
  task automatic run_engine(input string tag);
    int left, e, cyc;
    left = 0;
    for (int i = 0; i < N; i++) left += q[i].size();
    drive_req();
    cyc = 0;
    while (left > 0 && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.req_ack != '0) begin
        if (m_owner >= 0) e = m_owner;
        else begin
          e = -1;
          for (int k = 0; k < N; k++)
            if (e < 0 && q[(m_ptr + k) % N].size() != 0) e = (m_ptr + k) % N;
          m_burst = 0;
        end
        if (e < 0) chk({tag, "_ack_unexpected"}, 32'(bus.req_ack), 32'd0);
        else begin
          chk({tag, "_ack"},   32'(bus.req_ack), 32'(1) << e);
          chk({tag, "_grant"}, 32'(bus.grant),   32'(1) << e);
          chk({tag, "_data"},  32'(bus.uart_data), 32'(q[e][0]));
          void'(q[e].pop_front());
          left--;
          if (q[e].size() != 0 && m_burst < MAXB - 1) begin
            m_owner = e;
            m_burst++;
          end else begin
            m_owner = -1;
            m_ptr = (e + 1) % N;
          end
          drive_req();
        end
      end
    end
    chk({tag, "_left"}, 32'(left), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, nack, k;
    bus.req = '0;
    bus.req_data = '0;
    hold_low = 1'b1;
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_send",  32'(bus.uart_send), 32'd0);
    chk("rst_data",  32'(bus.uart_data), 32'd0);
    chk("rst_ack",   32'(bus.req_ack), 32'd0);
    chk("rst_err",   32'(bus.err_timeout), 32'd0);

    // Held off while the transmitter reports busy.
    bus.req = 4'b0001;
    bus.req_data[7:0] = 8'h5A;
    rst = 1'b0;
    repeat (4) tick();
    chk("hold_grant", 32'(bus.grant), 32'd0);
    chk("hold_busy",  32'(bus.busy), 32'd0);
    hold_low = 1'b0;
    wait_sig(0, 10, "first_grant");
    chk("first_grant", 32'(bus.grant), 32'd1);
    chk("first_data",  32'(bus.uart_data), 32'h5A);
    wait_sig(1, 20, "first_ack");
    bus.req = '0;
    repeat (15) tick();
    do_reset();

    // Single request, then ptr must have moved to 2.
    bus.req_data = 32'h0000_A500;
    bus.req = 4'b0010;
    wait_sig(0, 10, "single_grant");
    chk("single_grant", 32'(bus.grant), 32'b0010);
    chk("single_send",  32'(bus.uart_send), 32'd1);
    chk("single_data",  32'(bus.uart_data), 32'hA5);
    wait_sig(1, 20, "single_ack");
    chk("single_ack", 32'(bus.req_ack), 32'b0010);
    bus.req = '0;
    nack = 0;
    repeat (20) begin
      tick();
      if (bus.req_ack != '0) nack++;
    end
    chk("single_extra_ack", 32'(nack), 32'd0);
    chk("single_idle_grant", 32'(bus.grant), 32'd0);
    chk("single_idle_busy",  32'(bus.busy), 32'd0);
    bus.req = 4'b0111;
    wait_sig(0, 5, "ptr_grant");
    chk("ptr_grant", 32'(bus.grant), 32'b0100);
    bus.req = '0;
    wait_sig(1, 20, "ptr_ack");
    repeat (15) tick();
    do_reset();

    // Early drop of req[3] during SEND.
    bus.req_data = 32'h3C00_0000;
    bus.req = 4'b1000;
    wait_sig(0, 10, "drop_grant");
    chk("drop_grant", 32'(bus.grant), 32'b1000);
    tick();
    bus.req = '0;
    wait_sig(1, 20, "drop_ack");
    chk("drop_ack",  32'(bus.req_ack), 32'b1000);
    chk("drop_data", 32'(bus.uart_data), 32'h3C);
    s0 = nsend;
    repeat (25) tick();
    chk("drop_no_resend", 32'(nsend - s0), 32'd0);
    chk("drop_busy", 32'(bus.busy), 32'd0);
    do_reset();

    // Timeout against a transmitter that never leaves idle.
    stub = 1'b1;
    bus.req_data = 32'h00C3_00B4;
    bus.req = 4'b0101;
    wait_sig(0, 10, "to_grant");
    chk("to_grant", 32'(bus.grant), 32'b0001);
    k = 0; nack = 0;
    while (!bus.err_timeout && k < 20) begin
      tick();
      k++;
      if (bus.req_ack != '0) nack++;
    end
    chk("to_cycles", 32'(k), 32'(TO));
    chk("to_err",    32'(bus.err_timeout), 32'd1);
    chk("to_send",   32'(bus.uart_send), 32'd0);
    chk("to_grant_clr", 32'(bus.grant), 32'd0);
    chk("to_no_ack", 32'(nack), 32'd0);
    tick();
    chk("to_rotate", 32'(bus.grant), 32'b0100);
    chk("to_err_pulse", 32'(bus.err_timeout), 32'd0);
    bus.req = '0;
    wait_sig(2, 15, "to_second");
    stub = 1'b0;
    repeat (3) tick();
    do_reset();

    // Reset while in DRAIN with a frame still in flight.
    bus.req_data = 32'h0000_0011;
    bus.req = 4'b0001;
    wait_sig(0, 10, "rstd_grant");
    wait_sig(1, 20, "rstd_ack");
    rst = 1'b1;
    #1;
    chk("rstd_grant", 32'(bus.grant), 32'd0);
    chk("rstd_send",  32'(bus.uart_send), 32'd0);
    chk("rstd_busy",  32'(bus.busy), 32'd0);
    chk("rstd_data",  32'(bus.uart_data), 32'd0);
    chk("rstd_ack",   32'(bus.req_ack), 32'd0);
    tick();
    rst = 1'b0;
    bus.req = 4'b0110;
    repeat (3) tick();
    chk("rstd_done_low", 32'(bus.uart_done), 32'd0);
    chk("rstd_wait_grant", 32'(bus.grant), 32'd0);
    chk("rstd_wait_busy",  32'(bus.busy), 32'd0);
    wait_sig(0, 20, "rstd_rearb");
    chk("rstd_rearb", 32'(bus.grant), 32'b0010);
    bus.req = '0;
    wait_sig(1, 20, "rstd_ack2");
    repeat (15) tick();
    do_reset();

    // Directed rotation: one byte each.
    for (int i = 0; i < N; i++) q[i].push_back(8'(8'hA0 + i));
    run_engine("rr");
    do_reset();

    // Burst cap: requester 2 has more bytes than one grant allows.
    q[0].push_back(8'h10);
    for (int i = 0; i < 5; i++) q[2].push_back(8'(8'h20 + i));
    run_engine("burst");
    do_reset();

    // Random queue contents.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) q[i].push_back(8'($urandom));
      end
      run_engine("rand");
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/nexi_uart_tx_sched.md
# nexi_uart_tx_sched

Round-robin scheduler that shares one `nexi_uart_tx` transmitter between `NREQ` byte producers. It arbitrates, latches the winner's byte, and drives the transmitter's `command_send`/`data` inputs. It tracks the transmitter's `done_ack` handshake and lets a granted requester stream a bounded burst of bytes before the grant rotates. It sits between on-chip producers (debug console, status reporter, etc.) and the transmitter, on the same `clk_1x_bps` bit clock.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: max consecutive bytes per grant, 1..255.
- `ACK_TIMEOUT`, 8: cycles allowed for `uart_done` to fall after `uart_send` rises, 4..255.

- `clk_1x_bps` in 1: bit clock, shared with the transmitter.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: level request, one bit per requester; held high while the requester has bytes.
- `req_data` in 8*NREQ: byte of requester i on bits [8i+7:8i].
- `req_ack` out NREQ: one-cycle pulse; the byte of requester i was accepted by the transmitter.
- `grant` out NREQ: one-hot current owner; all zero when idle.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: one-cycle pulse when the transmitter failed to acknowledge.
- `uart_send` out 1: to transmitter `command_send`.
- `uart_data` out 8: to transmitter `data`.
- `uart_done` in 1: from transmitter `done_ack`; high means idle.

## Operation
- All outputs are registered. Reset values: `grant`=0, `req_ack`=0, `busy`=0, `err_timeout`=0, `uart_send`=0, `uart_data`=0. The rotation pointer `ptr` resets to 0, `burst_cnt` to 0, and the state to IDLE.
- States: IDLE, SEND, DRAIN.
- **IDLE:**
  - If `uart_done`=1 and `req`≠0, pick the first set `req` bit searching from `ptr` upward with wrap-around.
  - Latch the winner's byte into `uart_data`, set `grant` one-hot, set `uart_send`=1, clear `burst_cnt` and the timeout counter, and go to SEND.
  - If `uart_done`=0, do not arbitrate.
- **SEND:**
  - Hold `uart_send`=1 and `uart_data` stable; increment the timeout counter.
  - On `uart_done`=0: set `uart_send`=0, pulse `req_ack[winner]`, and go to DRAIN.
  - If the counter reaches `ACK_TIMEOUT` first: set `uart_send`=0, pulse `err_timeout`, give no `req_ack`, clear `grant`, set `ptr`=winner+1 (mod NREQ), and go to IDLE.
- **DRAIN:**
  - Wait for `uart_done`=1.
  - If then `req[winner]`=1 and `burst_cnt` < `MAX_BURST`-1: increment `burst_cnt`, latch the new `req_data` slice, set `uart_send`=1, and return to SEND with the timeout counter cleared.
  - Otherwise: clear `grant`, set `ptr`=winner+1 (mod NREQ), and go to IDLE.
- `req[winner]` dropping during SEND does not abort; the latched byte completes and is acked. The drop only ends the burst at DRAIN exit.
- `req` bits of non-owners are ignored while `busy`=1.
- `req_data` is sampled only on the IDLE→SEND and DRAIN→SEND transitions. After a `req_ack`, a requester must present its next byte before `uart_done` returns high, which is at least 8 cycles later.
- `rst` asserted in any state immediately forces the reset values. A frame already started in the transmitter is not this block's concern. After reset release, the block waits in IDLE for `uart_done`=1.

## Timing
- `req` rising at edge N (`uart_done`=1, idle) gives `grant` and `uart_send` high after edge N+1.
- `uart_done` falls 3 cycles after `uart_send` rises, due to the transmitter's 2-flop sync plus its register. `req_ack` is high in the cycle after the low `uart_done` is sampled.
- Per byte: the transmitter takes about 11 cycles from falling to rising `uart_done`. The next byte of a burst gets `uart_send` the cycle after `uart_done` is seen high, so there is no IDLE cycle inside a burst.
- Between owners, one IDLE cycle is inserted.
- `uart_send` is never high while `uart_done` is sampled low in IDLE. It is never asserted for a second byte before `uart_done` has been seen high.

## Test plan
- Single request: `req`=4'b0010 with `req_data[15:8]`=8'hA5 → `grant`=0010 and `uart_send`=1 with `uart_data`=A5. Expect exactly one `req_ack[1]` pulse, then `grant`=0 and `ptr`=2.
- Round-robin: `req`=4'b1111 continuously with `MAX_BURST`=1 → grant order 0,1,2,3,0, with one `req_ack` per grant.
- Burst cap: `req[2]` held high with `MAX_BURST`=3 and `req`=4'b0101 → three bytes to requester 2 back-to-back, then the grant moves to 0.
- Timeout: a stub holds `uart_done`=1 → `err_timeout` pulses after 8 SEND cycles, no `req_ack`, `uart_send`=0, and the grant rotates.
- Early drop: `req[3]` falls during SEND → the byte still completes with `req_ack[3]`, the block returns to IDLE after DRAIN, and no second byte is sent.
- Reset mid-DRAIN: `rst` pulsed → all outputs 0 at once; after release the block stays idle until `uart_done`=1, then arbitrates from `ptr`=0.
